// File: rtl/md_ctrl.sv
// HI/LO multiply/divide sequencing controller.
// Issues one start pulse per accepted mult/div-class operation, counts its
// latency, pulses the HI/LO commit, and stalls HI/LO users in D meanwhile.
module md_ctrl #(
   parameter int unsigned MULT_LAT = 5,
   parameter int unsigned DIV_LAT  = 10,
   parameter int unsigned CNT_W    = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       op_valid,
   input  logic [3:0] op_code,
   input  logic       inter,
   input  logic       d_uses_hilo,
   output logic       md_start,
   output logic [2:0] md_kind,
   output logic       md_commit,
   output logic       wr_hi,
   output logic       wr_lo,
   output logic       busy,
   output logic       stall_d,
   output logic       err
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       kind_r;

   logic             acc;
   logic             is_mult;
   logic             is_div;
   logic [2:0]       dec_kind;
   logic [CNT_W-1:0] lat_m1;

   // Decode the E-stage opcode into a datapath kind and latency class.
   always_comb begin
      is_mult  = 1'b0;
      is_div   = 1'b0;
      dec_kind = '0;
      case (op_code)
         4'd1: begin is_mult = 1'b1; dec_kind = 3'd0; end
         4'd2: begin is_mult = 1'b1; dec_kind = 3'd1; end
         4'd3: begin is_div  = 1'b1; dec_kind = 3'd2; end
         4'd4: begin is_div  = 1'b1; dec_kind = 3'd3; end
         4'd5: begin is_mult = 1'b1; dec_kind = 3'd4; end
         4'd6: begin is_mult = 1'b1; dec_kind = 3'd5; end
         default: ;
      endcase
      lat_m1 = is_div ? DIV_CNT : MULT_CNT;
   end

   // Issue, write-enable and occupancy outputs derived from acceptance and state.
   always_comb begin
      acc       = op_valid & ~inter & (state == IDLE);
      md_start  = acc & (is_mult | is_div);
      wr_hi     = acc & (op_code == 4'd7);
      wr_lo     = acc & (op_code == 4'd8);
      md_kind   = md_start ? dec_kind : kind_r;
      md_commit = (state == DONE);
      busy      = md_start | (state != IDLE);
      stall_d   = busy & d_uses_hilo;
   end

   // Sequencing FSM: latency counter, latched kind and sticky protocol error.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         kind_r <= '0;
         err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (md_start) begin
                  kind_r <= dec_kind;
                  cnt    <= lat_m1;
                  state  <= (lat_m1 == '0) ? DONE : RUN;
               end
               if (acc && (op_code > 4'd8))
                  err <= 1'b1;
            end
            RUN: begin
               cnt <= cnt - 1'b1;
               if (cnt == CNT_W'(1))
                  state <= DONE;
            end
            DONE: begin
               cnt   <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         // A new HI/LO operation while occupied is dropped and flagged.
         if (op_valid && !inter && (op_code != 4'd0) && (state != IDLE))
            err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: default instance plus a MULT_LAT=1 instance
// sharing one stimulus stream, checked every cycle against a timeline model.
module tb_md_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       op_valid = 1'b0;
   logic [3:0] op_code = 4'd0;
   logic       inter = 1'b0;
   logic       d_uses_hilo = 1'b0;

   logic       s_start  [2];
   logic [2:0] s_kind   [2];
   logic       s_commit [2];
   logic       s_wrhi   [2];
   logic       s_wrlo   [2];
   logic       s_busy   [2];
   logic       s_stall  [2];
   logic       s_err    [2];

   int compared = 0;
   int mismatched = 0;

   md_ctrl dut0 (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
      .inter(inter), .d_uses_hilo(d_uses_hilo),
      .md_start(s_start[0]), .md_kind(s_kind[0]), .md_commit(s_commit[0]),
      .wr_hi(s_wrhi[0]), .wr_lo(s_wrlo[0]), .busy(s_busy[0]),
      .stall_d(s_stall[0]), .err(s_err[0])
   );

   md_ctrl #(.MULT_LAT(1)) dut1 (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
      .inter(inter), .d_uses_hilo(d_uses_hilo),
      .md_start(s_start[1]), .md_kind(s_kind[1]), .md_commit(s_commit[1]),
      .wr_hi(s_wrhi[1]), .wr_lo(s_wrlo[1]), .busy(s_busy[1]),
      .stall_d(s_stall[1]), .err(s_err[1])
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Timeline model: an accepted op issued in cycle t commits in cycle t+LAT
   // and the unit counts as occupied for every cycle up to and including it.
   int         mult_lat [2] = '{5, 1};
   int         div_lat  = 10;
   int         cyc = 0;
   int         commit_at [2] = '{-1, -1};
   logic [2:0] m_kind [2] = '{3'd0, 3'd0};
   logic       m_err [2] = '{1'b0, 1'b0};

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         bit occ, acc, e_start, e_commit, e_busy, e_hi, e_lo;
         int e_kind;
         if (reset) begin
            commit_at[i] = -1;
            m_kind[i] = 3'd0;
            m_err[i] = 1'b0;
            occ = 0; acc = 0; e_start = 0; e_commit = 0; e_busy = 0;
            e_hi = 0; e_lo = 0; e_kind = 0;
         end else begin
            occ      = (cyc <= commit_at[i]);
            acc      = op_valid && !inter && !occ;
            e_start  = acc && (op_code >= 4'd1) && (op_code <= 4'd6);
            e_hi     = acc && (op_code == 4'd7);
            e_lo     = acc && (op_code == 4'd8);
            e_commit = occ && (cyc == commit_at[i]);
            e_busy   = e_start || occ;
            e_kind   = e_start ? int'(op_code) - 1 : int'(m_kind[i]);
         end
         check($sformatf("m%0d.start", i), int'(s_start[i]), int'(e_start));
         check($sformatf("m%0d.commit", i), int'(s_commit[i]), int'(e_commit));
         check($sformatf("m%0d.busy", i), int'(s_busy[i]), int'(e_busy));
         check($sformatf("m%0d.stall", i), int'(s_stall[i]), int'(e_busy && d_uses_hilo));
         check($sformatf("m%0d.wr_hi", i), int'(s_wrhi[i]), int'(e_hi));
         check($sformatf("m%0d.wr_lo", i), int'(s_wrlo[i]), int'(e_lo));
         check($sformatf("m%0d.err", i), int'(s_err[i]), int'(m_err[i]));
         if (e_busy || reset)
            check($sformatf("m%0d.kind", i), int'(s_kind[i]), e_kind);
         if (!reset) begin
            if (op_valid && !inter &&
                ((occ && op_code != 4'd0) || (!occ && op_code > 4'd8)))
               m_err[i] = 1'b1;
            if (e_start) begin
               commit_at[i] = cyc + ((op_code == 4'd3 || op_code == 4'd4) ? div_lat : mult_lat[i]);
               m_kind[i] = op_code[2:0] - 3'd1;
            end
         end
      end
      cyc++;
   end

   // One stimulus cycle: drive after the edge, return just after the sampling edge.
   task automatic step(input logic v, input logic [3:0] c, input logic i, input logic u);
      @(posedge clk);
      #1;
      op_valid = v; op_code = c; inter = i; d_uses_hilo = u;
      @(negedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk); #1;
      check("rst.busy", int'(s_busy[0]), 0);
      check("rst.kind", int'(s_kind[0]), 0);
      check("rst.err", int'(s_err[0]), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      step(0, 0, 0, 0);

      // mult: busy cycles 0..5, commit at 5; 1-cycle instance commits at 1
      step(1, 4'd1, 0, 0);
      check("mult.start", int'(s_start[0]), 1);
      check("mult.kind", int'(s_kind[0]), 0);
      for (int k = 1; k <= 6; k++) begin
         step(0, 0, 0, 0);
         check($sformatf("mult.busy%0d", k), int'(s_busy[0]), int'(k <= 5));
         check($sformatf("mult.commit%0d", k), int'(s_commit[0]), int'(k == 5));
         check($sformatf("lat1.commit%0d", k), int'(s_commit[1]), int'(k == 1));
         check($sformatf("lat1.busy%0d", k), int'(s_busy[1]), int'(k <= 1));
      end

      // divu with a HI/LO user parked in D: stall cycles 0..10
      step(1, 4'd4, 0, 1);
      check("divu.stall0", int'(s_stall[0]), 1);
      for (int k = 1; k <= 11; k++) begin
         step(0, 0, 0, 1);
         check($sformatf("divu.stall%0d", k), int'(s_stall[0]), int'(k <= 10));
         check($sformatf("divu.commit%0d", k), int'(s_commit[0]), int'(k == 10));
      end
      step(0, 0, 0, 0);

      // mthi accepted, mtlo killed by interrupt
      step(1, 4'd7, 0, 0);
      check("mthi.wr_hi", int'(s_wrhi[0]), 1);
      check("mthi.busy", int'(s_busy[0]), 0);
      step(1, 4'd8, 1, 0);
      check("mtlo.wr_lo", int'(s_wrlo[0]), 0);
      check("mtlo.wr_hi", int'(s_wrhi[0]), 0);
      step(0, 0, 0, 0);
      check("mtx.busy", int'(s_busy[0]), 0);

      // madd, then a killed msub, then a live msub while occupied
      step(1, 4'd5, 0, 0);
      check("madd.kind", int'(s_kind[0]), 4);
      step(0, 0, 0, 0);
      step(1, 4'd6, 1, 0);
      check("madd.kill_start", int'(s_start[0]), 0);
      step(1, 4'd6, 0, 0);
      check("madd.busy_start", int'(s_start[0]), 0);
      step(0, 0, 0, 0);
      check("madd.err", int'(s_err[0]), 1);
      step(0, 0, 0, 0);
      check("madd.commit5", int'(s_commit[0]), 1);
      check("madd.kind5", int'(s_kind[0]), 4);
      for (int k = 0; k < 4; k++) step(0, 0, 0, 0);

      // reserved opcode sets err on the 1-cycle instance as well
      step(1, 4'd12, 0, 0);
      step(0, 0, 0, 0);
      check("resv.err", int'(s_err[1]), 1);

      // div abandoned by async reset in cycle 4
      step(1, 4'd3, 0, 0);
      for (int k = 1; k <= 3; k++) step(0, 0, 0, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      check("arst.busy", int'(s_busy[0]), 0);
      check("arst.commit", int'(s_commit[0]), 0);
      check("arst.kind", int'(s_kind[0]), 0);
      check("arst.err", int'(s_err[0]), 0);
      @(negedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int k = 6; k <= 12; k++) begin
         step(0, 0, 0, 0);
         check($sformatf("arst.commit%0d", k), int'(s_commit[0]), 0);
         check($sformatf("arst.busy%0d", k), int'(s_busy[0]), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
